// File: rtl/hazard_if.sv
// Hazard controller port bundle: pipeline-side hazard indications in,
// hold/bubble controls and the stall counter out.
interface hazard_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_wreg;
    logic             ex_mem_rd;
    logic             ex_branch_err;
    logic             mem_struct;
    logic             mem_io;
    logic             perf_clr;
    logic             pc_keep;
    logic             if_keep;
    logic             id_keep;
    logic             ex_keep;
    logic             if_clear;
    logic             id_clear;
    logic             mem_clear;
    logic             io_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, ex_wreg, ex_mem_rd, ex_branch_err,
               mem_struct, mem_io, perf_clr,
        input  pc_keep, if_keep, id_keep, ex_keep, if_clear, id_clear,
               mem_clear, io_busy, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_wreg, ex_mem_rd, ex_branch_err,
               mem_struct, mem_io, perf_clr,
        output pc_keep, if_keep, id_keep, ex_keep, if_clear, id_clear,
               mem_clear, io_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, use stall, I-RAM structural stall
// and a multi-cycle full freeze for slow IO, plus a saturating stall counter.
module hazard_ctrl #(
    parameter int               REG_W    = 4,
    parameter logic [REG_W-1:0] NO_REG   = {REG_W{1'b1}},
    parameter bit               FWD      = 1'b1,
    parameter int               WAIT_CYC = 2,
    parameter int               CNT_W    = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);

    localparam int CW = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC);
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYC >= 2) ? CW'(WAIT_CYC - 2) : '0;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic freeze, use_hz;
    logic pc_keep, if_keep, id_keep, ex_keep;
    logic if_clear, id_clear, mem_clear, io_busy;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (hz.perf_clr)
            stall_cnt <= '0;
        else if (pc_keep)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign use_hz = (hz.ex_wreg != NO_REG) &&
                    ((hz.id_rs1 == hz.ex_wreg) || (hz.id_rs2 == hz.ex_wreg)) &&
                    (hz.ex_mem_rd || !FWD);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = 1'b0;
        case (state)
            S_RUN: begin
                if (hz.mem_io && (WAIT_CYC != 0)) begin
                    freeze = 1'b1;
                    if (WAIT_CYC >= 2) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                freeze = 1'b1;
                if (cnt == '0) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            // DONE lets the IO instruction leave MEM before mem_io is honoured again
            S_DONE:  state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        pc_keep   = 1'b0;
        if_keep   = 1'b0;
        id_keep   = 1'b0;
        ex_keep   = 1'b0;
        if_clear  = 1'b0;
        id_clear  = 1'b0;
        mem_clear = 1'b0;
        io_busy   = 1'b0;
        if (!rst) begin
            // outputs stay quiet throughout reset, even if a freeze was in flight
        end else if (freeze) begin
            pc_keep   = 1'b1;
            if_keep   = 1'b1;
            id_keep   = 1'b1;
            ex_keep   = 1'b1;
            mem_clear = 1'b1;
            io_busy   = 1'b1;
        end else if (hz.ex_branch_err) begin
            if_clear = 1'b1;
            id_clear = 1'b1;
        end else if (use_hz) begin
            pc_keep  = 1'b1;
            if_keep  = 1'b1;
            id_clear = 1'b1;
        end else if (hz.mem_struct) begin
            pc_keep  = 1'b1;
            if_clear = 1'b1;
        end
    end

    assign hz.pc_keep   = pc_keep;
    assign hz.if_keep   = if_keep;
    assign hz.id_keep   = id_keep;
    assign hz.ex_keep   = ex_keep;
    assign hz.if_clear  = if_clear;
    assign hz.id_clear  = id_clear;
    assign hz.mem_clear = mem_clear;
    assign hz.io_busy   = io_busy;
    assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: A = forwarding, 3-cycle IO, 4-bit counter;
// B = no forwarding, 1-cycle IO, 16-bit counter. Both see the same inputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rs1, rs2, wreg;
    logic       mem_rd, br, st, io, clr;
    int         n_run  = 0;
    int         n_fail = 0;

    // output vector order: pc_keep if_keep id_keep ex_keep if_clear id_clear mem_clear io_busy
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_USE    = 8'b1100_0100;
    localparam logic [7:0] O_BRANCH = 8'b0000_1100;
    localparam logic [7:0] O_STRUCT = 8'b1000_1000;
    localparam logic [7:0] O_FREEZE = 8'b1111_0011;

    always #5 clk = ~clk;

    hazard_if #(.REG_W(4), .CNT_W(4))  if_a ();
    hazard_if #(.REG_W(4), .CNT_W(16)) if_b ();

    assign if_a.id_rs1 = rs1;   assign if_b.id_rs1 = rs1;
    assign if_a.id_rs2 = rs2;   assign if_b.id_rs2 = rs2;
    assign if_a.ex_wreg = wreg; assign if_b.ex_wreg = wreg;
    assign if_a.ex_mem_rd = mem_rd;   assign if_b.ex_mem_rd = mem_rd;
    assign if_a.ex_branch_err = br;   assign if_b.ex_branch_err = br;
    assign if_a.mem_struct = st;      assign if_b.mem_struct = st;
    assign if_a.mem_io = io;          assign if_b.mem_io = io;
    assign if_a.perf_clr = clr;       assign if_b.perf_clr = clr;

    hazard_ctrl #(.REG_W(4), .FWD(1'b1), .WAIT_CYC(3), .CNT_W(4))  dut_a (.clk(clk), .rst(rst), .hz(if_a));
    hazard_ctrl #(.REG_W(4), .FWD(1'b0), .WAIT_CYC(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .hz(if_b));

    wire [7:0] oa = {if_a.pc_keep, if_a.if_keep, if_a.id_keep, if_a.ex_keep,
                     if_a.if_clear, if_a.id_clear, if_a.mem_clear, if_a.io_busy};
    wire [7:0] ob = {if_b.pc_keep, if_b.if_keep, if_b.id_keep, if_b.ex_keep,
                     if_b.if_clear, if_b.id_clear, if_b.mem_clear, if_b.io_busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1 = 4'd0; rs2 = 4'd0; wreg = 4'hF;
        mem_rd = 1'b0; br = 1'b0; st = 1'b0; io = 1'b0; clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        io = 1'b1;
        #1;
        chk("reset_outs_a", oa, O_NONE);
        chk("reset_outs_b", ob, O_NONE);
        chk("reset_cnt_a", if_a.stall_cnt, 0);
        step(); step();
        io = 1'b0;
        rst = 1'b1;
        #1;
        chk("run_idle_a", oa, O_NONE);

        // load-use with forwarding: stalls both variants
        mem_rd = 1'b1; wreg = 4'd3; rs2 = 4'd3;
        #1;
        chk("load_use_a", oa, O_USE);
        chk("load_use_b", ob, O_USE);
        step();
        idle();
        #1;
        chk("load_use_1cyc_a", oa, O_NONE);
        chk("load_use_cnt_a", if_a.stall_cnt, 1);

        mem_rd = 1'b1; wreg = 4'hF; rs1 = 4'hF;
        #1;
        chk("sentinel_a", oa, O_NONE);
        chk("sentinel_b", ob, O_NONE);

        idle();
        wreg = 4'd5; rs1 = 4'd5;
        #1;
        chk("alu_use_fwd_a", oa, O_NONE);
        chk("alu_use_nofwd_b", ob, O_USE);

        idle();
        br = 1'b1; mem_rd = 1'b1; wreg = 4'd3; rs1 = 4'd3; st = 1'b1;
        #1;
        chk("branch_prio_a", oa, O_BRANCH);
        chk("branch_prio_b", ob, O_BRANCH);

        idle();
        st = 1'b1;
        #1;
        chk("struct_a", oa, O_STRUCT);
        mem_rd = 1'b1; wreg = 4'd3; rs1 = 4'd3;
        #1;
        chk("use_struct_a", oa, O_USE);

        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        chk("clr_cnt_a", if_a.stall_cnt, 0);
        chk("clr_cnt_b", if_b.stall_cnt, 0);

        // IO freeze, mem_io held for 4 cycles, branch raised from cycle 2
        io = 1'b1;
        #1;
        chk("io_c0_a", oa, O_FREEZE);
        chk("io_c0_b", ob, O_FREEZE);
        step();
        br = 1'b1;
        #1;
        chk("io_c1_a", oa, O_FREEZE);
        chk("io_c1_done_b", ob, O_BRANCH);
        step();
        chk("io_c2_a", oa, O_FREEZE);
        chk("io_c2_refreeze_b", ob, O_FREEZE);
        step();
        chk("io_c3_done_a", oa, O_BRANCH);
        chk("io_c3_done_b", ob, O_BRANCH);
        step();
        idle();
        #1;
        chk("io_run_a", oa, O_NONE);
        chk("io_cnt_a", if_a.stall_cnt, 3);
        chk("io_cnt_b", if_b.stall_cnt, 2);

        // async reset in the middle of WAIT
        io = 1'b1;
        step();
        io = 1'b0;
        #1;
        chk("wait_freeze_a", oa, O_FREEZE);
        rst = 1'b0;
        #1;
        chk("async_rst_outs_a", oa, O_NONE);
        chk("async_rst_cnt_a", if_a.stall_cnt, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_run_a", oa, O_NONE);
        step();
        chk("post_rst_step_a", oa, O_NONE);
        chk("post_rst_cnt_a", if_a.stall_cnt, 0);

        // saturation of the narrow counter
        st = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt_a", if_a.stall_cnt, 15);
        chk("nosat_cnt_b", if_b.stall_cnt, 20);
        clr = 1'b1;
        #1;
        chk("clr_keep_a", oa, O_STRUCT);
        step();
        chk("clr_prio_a", if_a.stall_cnt, 0);
        chk("clr_prio_b", if_b.stall_cnt, 0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage 16-bit CPU. It sits beside the IF/ID/EX/MEM pipeline registers and decides, every cycle, which stages hold and which receive a bubble. It covers four hazards: load-use (or any-write-use when forwarding is disabled), control hazards from branch mispredicts, the instruction-RAM structural conflict, and multi-cycle slow-IO accesses. A small FSM freezes the whole pipeline for the IO access, and a saturating counter counts PC stall cycles.

## Interface
- REG_W, 4, register-address width
- NO_REG, {REG_W{1'b1}}, "no destination" sentinel; never matches
- FWD, 1, 1 = EX→ID forwarding exists and only loads stall; 0 = any EX writer with a matching register stalls
- WAIT_CYC, 2, number of full-freeze cycles per slow-IO access; 0 disables IO freeze
- CNT_W, 16, width of the stall counter

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- ex_wreg  in  REG_W  destination of the instruction in EX (NO_REG if none)
- ex_mem_rd  in  1  instruction in EX is a load
- ex_branch_err  in  1  branch in EX mispredicted; PC is loading the target this cycle
- mem_struct  in  1  MEM is accessing instruction RAM this cycle
- mem_io  in  1  MEM is accessing a slow IO device
- perf_clr  in  1  synchronous clear of stall_cnt
- pc_keep, if_keep, id_keep, ex_keep  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
- if_clear, id_clear, mem_clear  out  1  load a bubble into IF/ID, ID/EX and MEM/WB
- io_busy  out  1  IO freeze active
- stall_cnt  out  CNT_W  saturating count of cycles with pc_keep=1

## Operation
- FSM states and transitions:
  - RUN → WAIT when mem_io=1 and WAIT_CYC≥2. The counter loads WAIT_CYC-2.
  - RUN → DONE when mem_io=1 and WAIT_CYC=1.
  - WAIT → DONE when the counter reaches 0. Otherwise the counter decrements.
  - DONE → RUN unconditionally.
- Freeze is active when (RUN and mem_io and WAIT_CYC≠0) or in WAIT.
  - During freeze, pc_keep, if_keep, id_keep and ex_keep are 1, mem_clear=1, io_busy=1, and all other outputs are 0.
  - ex_branch_err is ignored during freeze. EX is held, so the flag re-presents itself after the freeze.
- In DONE, mem_io is ignored for one cycle so the IO instruction can leave MEM. The other hazard rules apply as in RUN.
- Outside freeze, rules are evaluated in priority order:
  1. Branch: ex_branch_err=1 → if_clear=1, id_clear=1, pc_keep=0. This overrides load-use and structural.
  2. Use hazard: use = ex_wreg≠NO_REG and (id_rs1==ex_wreg or id_rs2==ex_wreg) and (ex_mem_rd or FWD==0).
     - use → pc_keep=1, if_keep=1, id_clear=1.
     - With mem_struct also active, the outputs are the same. Keep beats clear on IF/ID.
  3. Structural: mem_struct alone → pc_keep=1, if_clear=1.
  4. Otherwise all outputs are 0.
- Every output is driven on every path. No latches.
- stall_cnt:
  - On each clock edge with pc_keep=1 it adds 1, saturating at all-ones.
  - perf_clr has priority and sets it to 0 that edge.

## Timing
- All keep/clear outputs and io_busy are combinational from the inputs plus the registered state. They are valid in the same cycle the hazard appears.
- The state, the WAIT counter and stall_cnt update on the rising edge of clk.
- While rst=0:
  - state=RUN, counter=0, stall_cnt=0.
  - All keep/clear outputs and io_busy are forced to 0.
- Reset asserted mid-freeze aborts the freeze immediately, asynchronously.
- An IO access freezes for exactly WAIT_CYC cycles.
- A load-use stall lasts 1 cycle, because the load leaves EX.
- A branch flush lasts 1 cycle.

## Test plan
- Load-use, FWD=1: ex_mem_rd=1, ex_wreg=3, id_rs2=3 → pc_keep=if_keep=id_clear=1 for 1 cycle; stall_cnt +1.
- Sentinel and mode: ex_wreg=4'hF=id_rs1 with ex_mem_rd=1 → no stall. With FWD=0, ex_mem_rd=0, ex_wreg=5=id_rs1 → stall.
- Branch vs load-use vs structural: ex_branch_err=1 together with a load-use match and mem_struct=1 → if_clear=id_clear=1, pc_keep=0, if_keep=0.
- IO freeze, WAIT_CYC=3, mem_io held high for 4 cycles → freeze outputs for exactly 3 cycles, then a DONE cycle with no freeze, then RUN. ex_branch_err raised in cycle 2 → flush only in the DONE cycle.
- Async reset: assert rst=0 in the middle of WAIT → all outputs 0 immediately. After release, state is RUN and stall_cnt=0.
- Counter: CNT_W=4, hold mem_struct=1 for 20 cycles → stall_cnt saturates at 15. perf_clr=1 with pc_keep=1 → 0.
